// File: rtl/ws2812_frame_feeder.sv
// Holds one frame of GRB pixels and streams them into a PIO TX FIFO through the
// action/din command port, then waits for the FIFO to drain and the LEDs to latch.
module ws2812_frame_feeder #(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_W       = 3,
    parameter int LATCH_CYCLES = 2100,
    parameter int MINDEX       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        action,
    output logic [31:0]       din,
    output logic [1:0]        mindex,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic [2:0]        o_dbg_state
);

    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [3:0]        ACT_NONE = 4'd0;
    localparam logic [3:0]        ACT_PUSH = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PUSH  = 3'd2,
        S_DRAIN = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_index;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_action;
    logic [31:0]       r_din;
    logic [23:0]       r_rd_data;
    logic [23:0]       r_mem [NUM_LEDS];

    logic w_wr_ok;
    logic w_rd_en;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < NUM_EXT);
    assign w_rd_en = (r_state == S_FETCH);

    // Pixel RAM is not reset; a read that collides with a write sees the old word.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_index];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_action <= ACT_NONE;
            r_din    <= '0;
        end else begin
            r_action <= ACT_NONE;
            r_din    <= '0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped on purpose.
                    if (start && !r_done) begin
                        r_index <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    if (!tx_full) begin
                        r_action <= ACT_PUSH;
                        r_din    <= {r_rd_data, 8'h00};
                        if (r_index == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tx_empty) begin
                        r_cnt   <= '0;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == LAST_CNT) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign action      = r_action;
    assign din         = r_din;
    assign mindex      = 2'(MINDEX);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Directed bench for ws2812_frame_feeder: an 8-pixel instance checked through a
// push scoreboard and a 1-pixel instance checked for exact latency.
module tb_ws2812_frame_feeder;
  localparam int L = 2100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 8-pixel instance
  logic        wr_en8 = 1'b0;
  logic [2:0]  wr_addr8 = '0;
  logic [23:0] wr_data8 = '0;
  logic        start8 = 1'b0;
  logic        tx_full8 = 1'b0;
  logic        tx_empty8 = 1'b1;
  logic        busy8, done8;
  logic [3:0]  action8;
  logic [31:0] din8;
  logic [1:0]  mindex8;
  logic [2:0]  dbg8;

  // 1-pixel instance
  logic        wr_en1 = 1'b0;
  logic [0:0]  wr_addr1 = '0;
  logic [23:0] wr_data1 = '0;
  logic        start1 = 1'b0;
  logic        tx_full1 = 1'b0;
  logic        tx_empty1 = 1'b1;
  logic        busy1, done1;
  logic [3:0]  action1;
  logic [31:0] din1;
  logic [1:0]  mindex1;
  logic [2:0]  dbg1;

  ws2812_frame_feeder #(.NUM_LEDS(8), .ADDR_W(3), .LATCH_CYCLES(L), .MINDEX(0)) dut8 (
    .clk(clk), .reset_n(rst_n), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
    .start(start8), .busy(busy8), .done(done8), .action(action8), .din(din8),
    .mindex(mindex8), .tx_full(tx_full8), .tx_empty(tx_empty8), .o_dbg_state(dbg8)
  );

  ws2812_frame_feeder #(.NUM_LEDS(1), .ADDR_W(1), .LATCH_CYCLES(L), .MINDEX(0)) dut1 (
    .clk(clk), .reset_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .done(done1), .action(action1), .din(din1),
    .mindex(mindex1), .tx_full(tx_full1), .tx_empty(tx_empty1), .o_dbg_state(dbg1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  int last_push_cyc = 0;
  int done_cyc = 0;
  logic mon_en = 1'b0;
  logic full_q = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    full_q <= tx_full8;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: every push of the 8-pixel instance is checked against the queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (action8 == 4'd4) begin
        push_cnt++;
        last_push_cyc = cyc;
        chk("no_push_while_full", {31'b0, full_q}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_push: din %h, expected no push", din8);
        end else begin
          e = exp_q.pop_front();
          chk("push_din", din8, e);
        end
      end else begin
        chk("din_idle_zero", din8, 32'd0);
      end
      if (done8) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write8(input logic [2:0] a, input logic [23:0] d);
    wr_en8 = 1'b1;
    wr_addr8 = a;
    wr_data8 = d;
    step();
    wr_en8 = 1'b0;
  endtask

  task automatic pulse_start8();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("busy_after_start", {31'b0, busy8}, 32'd1);
  endtask

  task automatic wait_push(input int target, input int bound);
    int n = 0;
    while (push_cnt < target && n < bound) begin
      step();
      n++;
    end
    if (push_cnt < target) timeout("wait_push");
  endtask

  task automatic wait_done(input int prev, input int bound);
    int n = 0;
    while (done_cnt <= prev && n < bound) begin
      step();
      n++;
    end
    if (done_cnt <= prev) timeout("wait_done");
  endtask

  task automatic queue_ramp();
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i) << 8);
  endtask

  initial begin
    int base;
    int dbase;
    int s;
    int p;
    int d;
    int np;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_action", {28'b0, action8}, 32'd0);
    chk("rst_din", din8, 32'd0);
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_done", {31'b0, done8}, 32'd0);
    chk("rst_state", {29'b0, dbg8}, 32'd0);
    chk("mindex", {30'b0, mindex8}, 32'd0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Single-pixel frame on the 1-LED instance
    wr_en1 = 1'b1;
    wr_addr1 = 1'b0;
    wr_data1 = 24'hff00ff;
    step();
    wr_en1 = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    s = cyc;
    np = 0;
    p = 0;
    d = -1;
    for (int i = 0; i < L + 100; i++) begin
      if (action1 == 4'd4) begin
        np++;
        p = cyc;
        chk("px1_din", din1, 32'hff00ff00);
      end
      if (done1) begin
        d = cyc;
        break;
      end
      step();
    end
    if (d < 0) timeout("px1_done");
    chk("px1_push_count", 32'(np), 32'd1);
    chk("px1_push_latency", 32'(p - s), 32'd2);
    chk("px1_done_latency", 32'(d - p), 32'(L + 1));
    step();
    chk("px1_busy_after", {31'b0, busy1}, 32'd0);

    // Load ramp 1..8 into the 8-LED instance
    for (int i = 0; i < 8; i++) write8(3'(i), 24'(i + 1));

    // Frame 1: backpressure at pixel 3
    base = push_cnt;
    dbase = done_cnt;
    queue_ramp();
    pulse_start8();
    wait_push(base + 2, 100);
    tx_full8 = 1'b1;
    repeat (20) step();
    chk("bp_held", 32'(push_cnt - base), 32'd2);
    tx_full8 = 1'b0;
    wait_done(dbase, L + 500);
    chk("bp_push_count", 32'(push_cnt - base), 32'd8);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_done_latency", 32'(done_cyc - last_push_cyc), 32'(L + 1));
    chk("bp_busy_at_done", {31'b0, busy8}, 32'd0);
    repeat (3) step();

    // Frame 2: drain wait of 500 cycles
    tx_empty8 = 1'b0;
    base = push_cnt;
    dbase = done_cnt;
    queue_ramp();
    pulse_start8();
    wait_push(base + 8, 200);
    s = 0;
    while (cyc != last_push_cyc + 500 && s < 1000) begin
      step();
      s++;
    end
    chk("drain_no_done_yet", 32'(done_cnt - dbase), 32'd0);
    tx_empty8 = 1'b1;
    wait_done(dbase, L + 500);
    chk("drain_done_latency", 32'(done_cyc - last_push_cyc), 32'(L + 501));
    repeat (3) step();

    // Frame 3: restart while busy is ignored, pixel 7 rewritten mid-frame
    base = push_cnt;
    dbase = done_cnt;
    for (int i = 1; i <= 7; i++) exp_q.push_back(32'(i) << 8);
    exp_q.push_back(32'habcdef00);
    pulse_start8();
    wait_push(base + 3, 100);
    write8(3'd7, 24'habcdef);
    wait_push(base + 4, 100);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_done(dbase, L + 500);
    chk("restart_push_count", 32'(push_cnt - base), 32'd8);
    chk("restart_done_count", 32'(done_cnt - dbase), 32'd1);

    // start with done high is ignored; start one cycle later begins frame 4
    for (int i = 1; i <= 7; i++) exp_q.push_back(32'(i) << 8);
    exp_q.push_back(32'habcdef00);
    base = push_cnt;
    dbase = done_cnt;
    start8 = 1'b1;
    step();
    chk("start_on_done_ignored", {31'b0, busy8}, 32'd0);
    step();
    start8 = 1'b0;
    chk("start_after_done", {31'b0, busy8}, 32'd1);
    // This write lands on the edge that reads pixel 0: frame 4 keeps the old value.
    write8(3'd0, 24'h123456);
    wait_done(dbase, L + 500);
    chk("f4_push_count", 32'(push_cnt - base), 32'd8);
    repeat (3) step();

    // Frame 5: the collided write is visible now
    base = push_cnt;
    dbase = done_cnt;
    exp_q.push_back(32'h12345600);
    for (int i = 2; i <= 7; i++) exp_q.push_back(32'(i) << 8);
    exp_q.push_back(32'habcdef00);
    pulse_start8();
    wait_done(dbase, L + 500);
    chk("f5_push_count", 32'(push_cnt - base), 32'd8);
    chk("f5_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step();

    // Frame 6: reset while action=PUSH
    base = push_cnt;
    exp_q.push_back(32'h12345600);
    pulse_start8();
    wait_push(base + 1, 100);
    chk("abort_action_before", {28'b0, action8}, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_action", {28'b0, action8}, 32'd0);
    chk("abort_din", din8, 32'd0);
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    chk("abort_done", {31'b0, done8}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("abort_state_idle", {29'b0, dbg8}, 32'd0);
    chk("abort_no_push", 32'(push_cnt - base), 32'd1);
    chk("abort_busy_after", {31'b0, busy8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
